// File: rtl/wb_master_if.sv
// wb_master_if: Wishbone classic master for the CPU data port.
// Converts a one-cycle CPU load/store request into a single Wishbone
// read or write cycle, then reports completion status and read data.
// Optional watchdog: define WB_MASTER_TIMEOUT_EN to bound how long
// wbm_cyc_o may stay asserted without ack/err.
module wb_master_if #(
  parameter int ADDR_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // CPU side
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_BITS-1:0] cpu_addr_i,
  input  logic [3:0]           cpu_sel_i,
  input  logic [31:0]          cpu_data_i,
  output logic                 cpu_busy_o,
  output logic                 cpu_done_o,
  output logic                 cpu_err_o,
  output logic [31:0]          cpu_data_o,
  // Wishbone side
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [ADDR_BITS-3:0] wbm_addr_o,
  output logic [3:0]           wbm_sel_o,
  output logic                 wbm_we_o,
  output logic [31:0]          wbm_data_o,
  input  logic [31:0]          wbm_data_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i
);

  localparam int WA = ADDR_BITS - 2;

  // Watchdog limit must fit the 8-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_master_if: TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Request fields latched on acceptance and driven onto the bus.
  typedef struct packed {
    logic [WA-1:0] addr;
    logic [3:0]    sel;
    logic          we;
    logic [31:0]   data;
  } wb_req_t;

  state_e      state_q, state_d;
  wb_req_t     req_q, req_d;
  logic        cyc_q, cyc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout;

  // Byte offset within the word is not carried on the bus.
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] cnt_q, cnt_d;
  // Counter holds the number of silent BUS cycles already spent; the
  // cycle that sees it equal to the limit is the last one allowed.
  assign timeout = (cnt_q == TO_LIM);
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cyc_d   = cyc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          req_d   = '{addr: cpu_addr_i[ADDR_BITS-1:2], sel: cpu_sel_i,
                      we: cpu_we_i, data: cpu_data_i};
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      BUS: begin
        // Err has priority over a simultaneous ack.
        if (wbm_err_i) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (wbm_ack_i) begin
          err_d   = 1'b0;
          if (!req_q.we) rdata_d = wbm_data_i;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      DONE: begin
        // One turnaround cycle; requests here are dropped.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset kills any cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cpu_busy_o = busy_q;
  assign cpu_done_o = done_q;
  assign cpu_err_o  = err_q;
  assign cpu_data_o = rdata_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_addr_o = req_q.addr;
  assign wbm_sel_o  = req_q.sel;
  assign wbm_we_o   = req_q.we;
  assign wbm_data_o = req_q.data;

endmodule

// File: tb/tb_wb_master_if.sv
// tb_wb_master_if: table-driven vectors plus hand sequences for
// back-to-back, ignored requests, timeout and mid-cycle reset.
module tb_wb_master_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [15:0] cpu_addr_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_busy_o, cpu_done_o, cpu_err_o;
  logic [31:0] cpu_data_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [13:0] wbm_addr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_o;
  logic [31:0] wbm_data_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  wb_master_if #(.ADDR_BITS(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i),
    .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o), .cpu_err_o(cpu_err_o),
    .cpu_data_o(cpu_data_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_addr_o(wbm_addr_o),
    .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_data_o(wbm_data_o),
    .wbm_data_i(wbm_data_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          waits;
    logic [1:0]  resp;     // bit0 ack, bit1 err
    logic [31:0] rdata;
    logic [13:0] exp_addr;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    cpu_req_i = 1'b1; cpu_we_i = v.we; cpu_addr_i = v.addr;
    cpu_sel_i = v.sel; cpu_data_i = v.wdata;
    tick();
    cpu_req_i = 1'b0; cpu_data_i = 32'hFFFF_FFFF; cpu_addr_i = 16'hFFFF;
    chk($sformatf("v%0d c1 cyc", i), 32'(wbm_cyc_o), 32'd1);
    chk($sformatf("v%0d c1 stb", i), 32'(wbm_stb_o), 32'd1);
    chk($sformatf("v%0d c1 busy", i), 32'(cpu_busy_o), 32'd1);
    chk($sformatf("v%0d c1 addr", i), 32'(wbm_addr_o), 32'(v.exp_addr));
    chk($sformatf("v%0d c1 sel", i), 32'(wbm_sel_o), 32'(v.sel));
    chk($sformatf("v%0d c1 we", i), 32'(wbm_we_o), 32'(v.we));
    if (v.we) chk($sformatf("v%0d c1 wdata", i), wbm_data_o, v.wdata);
    for (int w = 0; w < v.waits; w++) begin
      wbm_data_i = 32'h5555_AAAA;
      tick();
      chk($sformatf("v%0d wait%0d cyc", i, w), 32'(wbm_cyc_o), 32'd1);
      chk($sformatf("v%0d wait%0d done", i, w), 32'(cpu_done_o), 32'd0);
      chk($sformatf("v%0d wait%0d addr", i, w), 32'(wbm_addr_o), 32'(v.exp_addr));
      chk($sformatf("v%0d wait%0d sel", i, w), 32'(wbm_sel_o), 32'(v.sel));
      if (v.we) chk($sformatf("v%0d wait%0d wdata", i, w), wbm_data_o, v.wdata);
    end
    wbm_ack_i = v.resp[0]; wbm_err_i = v.resp[1]; wbm_data_i = v.rdata;
    tick();
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_data_i = 32'h0;
    chk($sformatf("v%0d done", i), 32'(cpu_done_o), 32'd1);
    chk($sformatf("v%0d err", i), 32'(cpu_err_o), 32'(v.exp_err));
    chk($sformatf("v%0d data", i), cpu_data_o, v.exp_data);
    chk($sformatf("v%0d cyc off", i), 32'(wbm_cyc_o), 32'd0);
    chk($sformatf("v%0d busy in done", i), 32'(cpu_busy_o), 32'd1);
    tick();
    chk($sformatf("v%0d done pulse", i), 32'(cpu_done_o), 32'd0);
    chk($sformatf("v%0d busy idle", i), 32'(cpu_busy_o), 32'd0);
    chk($sformatf("v%0d err hold", i), 32'(cpu_err_o), 32'(v.exp_err));
    chk($sformatf("v%0d data hold", i), cpu_data_o, v.exp_data);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"}, 32'(cpu_busy_o), 32'd0);
    chk({nm, " done"}, 32'(cpu_done_o), 32'd0);
    chk({nm, " err"}, 32'(cpu_err_o), 32'd0);
    chk({nm, " data"}, cpu_data_o, 32'd0);
    chk({nm, " cyc"}, 32'(wbm_cyc_o), 32'd0);
    chk({nm, " stb"}, 32'(wbm_stb_o), 32'd0);
    chk({nm, " addr"}, 32'(wbm_addr_o), 32'd0);
    chk({nm, " sel"}, 32'(wbm_sel_o), 32'd0);
    chk({nm, " we"}, 32'(wbm_we_o), 32'd0);
    chk({nm, " wdata"}, wbm_data_o, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    //        we    addr      sel    wdata         waits resp  rdata         exp_addr  err   exp_data
    vecs[0] = '{1'b0, 16'h0104, 4'hF, 32'h0,        0, 2'b01, 32'hDEADBEEF, 14'h0041, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 16'h2000, 4'h3, 32'h12345678, 3, 2'b01, 32'hAAAA5555, 14'h0800, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 16'h0010, 4'hF, 32'h0,        1, 2'b11, 32'h11112222, 14'h0004, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 16'hFFFF, 4'h1, 32'h0,        2, 2'b01, 32'hCAFEF00D, 14'h3FFF, 1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 16'h0008, 4'hC, 32'h0BADF00D, 0, 2'b10, 32'h99999999, 14'h0002, 1'b1, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 16'h0100, 4'hF, 32'h0,        0, 2'b01, 32'h00000000, 14'h0040, 1'b0, 32'h00000000};
    vecs[6] = '{1'b0, 16'h0C00, 4'hF, 32'h0,        2, 2'b01, 32'h5A5A5A5A, 14'h0300, 1'b0, 32'h5A5A5A5A};

    // reset state
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("post reset");

    for (int i = 0; i < 6; i++) run_vec(i);

    // ack/err in IDLE are ignored
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_data_i = 32'hFFFF_FFFF;
    tick();
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_data_i = 32'h0;
    chk("idle ack done", 32'(cpu_done_o), 32'd0);
    chk("idle ack err", 32'(cpu_err_o), 32'd0);
    chk("idle ack data", cpu_data_o, 32'd0);
    chk("idle ack busy", 32'(cpu_busy_o), 32'd0);

    // requests during BUS and DONE are dropped, not queued
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0020; cpu_sel_i = 4'hF;
    tick();                                  // c1
    cpu_req_i = 1'b0;
    tick();                                  // c2
    cpu_req_i = 1'b1; cpu_addr_i = 16'h0FF0;
    tick();                                  // c3
    cpu_req_i = 1'b0;
    chk("busy req addr", 32'(wbm_addr_o), 32'h8);
    tick();                                  // c4
    wbm_ack_i = 1'b1; wbm_data_i = 32'h13572468;
    tick();                                  // c5 DONE
    wbm_ack_i = 1'b0; wbm_data_i = 32'h0;
    chk("busy req done", 32'(cpu_done_o), 32'd1);
    chk("busy req data", cpu_data_o, 32'h13572468);
    cpu_req_i = 1'b1;                        // request in DONE
    tick();                                  // c6 IDLE
    cpu_req_i = 1'b0;
    chk("done req cyc c6", 32'(wbm_cyc_o), 32'd0);
    chk("done req busy c6", 32'(cpu_busy_o), 32'd0);
    tick();
    chk("no queued cyc c7", 32'(wbm_cyc_o), 32'd0);
    tick();
    chk("no queued cyc c8", 32'(wbm_cyc_o), 32'd0);

    // back-to-back: req held high, zero-wait slave
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0200; cpu_sel_i = 4'hF;
    wbm_ack_i = 1'b1; wbm_data_i = 32'h01020304;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("b2b c%0d cyc", c), 32'(wbm_cyc_o), 32'((c % 3) == 1));
      chk($sformatf("b2b c%0d done", c), 32'(cpu_done_o), 32'((c % 3) == 2));
      chk($sformatf("b2b c%0d busy", c), 32'(cpu_busy_o), 32'((c % 3) != 0));
    end
    cpu_req_i = 1'b0;
    for (int c = 9; c <= 11; c++) begin
      tick();
      chk($sformatf("b2b c%0d no extra cyc", c), 32'(wbm_cyc_o), 32'd0);
    end
    wbm_ack_i = 1'b0; wbm_data_i = 32'h0;
    chk("b2b data", cpu_data_o, 32'h01020304);

    // silent slave
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0444;
    tick();                                  // c1: cyc rises
    cpu_req_i = 1'b0;
    chk("to c1 cyc", 32'(wbm_cyc_o), 32'd1);
`ifdef WB_MASTER_TIMEOUT_EN
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk($sformatf("to c%0d done", c), 32'(cpu_done_o), 32'd0);
      chk($sformatf("to c%0d cyc", c), 32'(wbm_cyc_o), 32'd1);
    end
    tick();                                  // c6 = 5 cycles after cyc rose
    chk("to done", 32'(cpu_done_o), 32'd1);
    chk("to err", 32'(cpu_err_o), 32'd1);
    chk("to cyc off", 32'(wbm_cyc_o), 32'd0);
    chk("to data", cpu_data_o, 32'h01020304);
    tick();
    chk("to idle busy", 32'(cpu_busy_o), 32'd0);
`else
    ndone = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (cpu_done_o) ndone++;
    end
    chk("no-to done count", 32'(ndone), 32'd0);
    chk("no-to cyc held", 32'(wbm_cyc_o), 32'd1);
    wbm_err_i = 1'b1;
    tick();
    wbm_err_i = 1'b0;
    chk("no-to done", 32'(cpu_done_o), 32'd1);
    chk("no-to err", 32'(cpu_err_o), 32'd1);
    chk("no-to cyc off", 32'(wbm_cyc_o), 32'd0);
    tick();
    chk("no-to idle busy", 32'(cpu_busy_o), 32'd0);
`endif

    // reset in the middle of a wait-stated read
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0300; cpu_sel_i = 4'h6;
    tick();                                  // c1
    cpu_req_i = 1'b0;
    tick();                                  // c2, still waiting
    chk("rst pre cyc", 32'(wbm_cyc_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    tick();
    chk("rst held done", 32'(cpu_done_o), 32'd0);
    chk("rst held cyc", 32'(wbm_cyc_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post rst done", 32'(cpu_done_o), 32'd0);
    chk("post rst cyc", 32'(wbm_cyc_o), 32'd0);
    run_vec(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_master_if.md
# wb_master_if

Wishbone master interface for the CPU data port. Turns a single-cycle CPU load/store request into one classic Wishbone read or write cycle. Completes on the slave's ack or err, or on an optional watchdog timeout. Returns read data and a completion status to the CPU. This block is the initiator side facing the bus adapter, which splits the IO address space across its devices.

## Interface
- `ADDR_BITS`, 16: Wishbone byte-address width; the bus carries bits [ADDR_BITS-1:2].
- `TIMEOUT_CYCLES`, 255: cycles `wbm_cyc_o` may stay asserted without ack/err. Range 1..255 (8-bit counter).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_req_i` in 1: request strobe, one cycle; sampled only when `cpu_busy_o`=0.
- `cpu_we_i` in 1: 1=write, 0=read.
- `cpu_addr_i` in ADDR_BITS: byte address; bits [1:0] ignored.
- `cpu_sel_i` in 4: byte lanes.
- `cpu_data_i` in 32: write data.
- `cpu_busy_o` out 1: transaction in flight.
- `cpu_done_o` out 1: one-cycle completion pulse.
- `cpu_err_o` out 1: valid with `cpu_done_o`; 1 = slave err or timeout.
- `cpu_data_o` out 32: read data, valid from `cpu_done_o` until the next accepted request.
- `wbm_cyc_o`, `wbm_stb_o` out 1: Wishbone cycle and strobe.
- `wbm_addr_o` out ADDR_BITS-2: word address.
- `wbm_sel_o` out 4; `wbm_we_o` out 1; `wbm_data_o` out 32.
- `wbm_data_i` in 32; `wbm_ack_i` in 1; `wbm_err_i` in 1.

## Operation
- FSM states: IDLE, BUS, DONE. Every output comes from a register.
- IDLE with `cpu_req_i`=1:
  - Latch `cpu_addr_i[ADDR_BITS-1:2]`, `cpu_sel_i`, `cpu_we_i` and `cpu_data_i` onto the `wbm_*` outputs.
  - Assert `wbm_cyc_o`, `wbm_stb_o` and `cpu_busy_o`; clear the timeout counter; go to BUS.
- BUS: `wbm_*` outputs held stable.
  - `wbm_err_i`=1: err=1. Err wins over a simultaneous ack.
  - Else `wbm_ack_i`=1: err=0; on a read, latch `wbm_data_i` into `cpu_data_o`.
  - Else the counter increments. When it reaches TIMEOUT_CYCLES, err=1.
  - On any of these three events: deassert `wbm_cyc_o`/`wbm_stb_o`, pulse `cpu_done_o`, set `cpu_err_o`, go to DONE.
- DONE: lasts one cycle. `cpu_busy_o` drops and the FSM returns to IDLE. `cpu_req_i` is ignored in DONE.
- Data retention:
  - `cpu_data_o` keeps its value after writes and after failed reads.
  - `cpu_err_o` holds until the next completion.
- `cpu_req_i` while `cpu_busy_o`=1 is ignored and does not queue.
- `wbm_ack_i`/`wbm_err_i` arriving in IDLE or DONE are ignored.
- Reset values: FSM=IDLE, counter=0, every output 0 (including `cpu_data_o` and the latched `wbm_*` fields).
- Reset mid-transaction: `wbm_cyc_o`/`wbm_stb_o` drop asynchronously; no `cpu_done_o` is issued for the aborted cycle.

## Timing
- Cycle 0: `cpu_req_i`=1 in IDLE.
- Cycle 1: `wbm_cyc_o`/`wbm_stb_o`=1.
- Ack sampled at cycle 1+N, where N≥0 is the slave wait-state count. At cycle 2+N, `cpu_done_o`=1 and `wbm_cyc_o`=0.
- A zero-wait slave gives a 2-cycle request-to-done latency.
- Earliest next request: cycle 3+N (sampled in IDLE), giving a throughput of one transaction per 3 cycles minimum.
- Timeout: with no response, `cpu_done_o`/`cpu_err_o` rise TIMEOUT_CYCLES+1 cycles after `wbm_cyc_o` rises.

## Configuration
- `WB_MASTER_TIMEOUT_EN`
  - Defined: watchdog counter present; behaviour as above.
  - Undefined: counter removed; BUS waits indefinitely for ack/err; `TIMEOUT_CYCLES` is unused.

## Test plan
- Zero-wait read: req addr=0x0104, sel=0xF; slave acks immediately with 0xDEADBEEF. Require `wbm_addr_o`=0x41 at cycle 1, `cpu_done_o` at cycle 2, `cpu_data_o`=0xDEADBEEF, `cpu_err_o`=0.
- Write with 3 wait states: req we=1, data=0x12345678, sel=0x3. Require `wbm_*` stable for 4 cycles, done at cycle 5, `cpu_data_o` unchanged.
- Slave err asserted together with ack on a read. Require `cpu_err_o`=1 and `cpu_data_o` unchanged.
- Timeout, TIMEOUT_CYCLES=4, silent slave. Require done+err exactly 5 cycles after `wbm_cyc_o` rises and `wbm_cyc_o`=0 on that cycle. Without the macro, require no done after 300 cycles.
- Back-to-back: hold `cpu_req_i`=1 continuously. Require transactions start only from IDLE (cycles 1, 4, 7 with zero-wait) and no extra cycles are issued.
- Reset mid-BUS: assert `rst_n`=0 asynchronously at cycle 2 of a wait-stated read. Require `wbm_cyc_o`=0 immediately, all outputs 0, no `cpu_done_o`; the next request after release completes normally.
